bus_responder: RTL and testbench

// - Target-side responder for the Z80 bus driven by module cpu: decodes MREQ/IORQ/RD/WR/A,

---
 rtl/lynx_pkg.sv | 33 +++
 rtl/bus_responder_int_gen.sv | 50 +++++
 rtl/bus_responder.sv | 115 +++++++++++
 tb/tb_bus_responder.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lynx_pkg.sv
// +------------------------------------------------------------------+
// | lynx_pkg : shared port addresses, defaults and bus helpers       |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package lynx_pkg;

  localparam logic [7:0]  PORT_BANK   = 8'h7F;
  localparam logic [7:0]  PORT_VCTL   = 8'h80;
  localparam logic [7:0]  PORT_DAC    = 8'h84;
  localparam logic [7:0]  BYTE_FF     = 8'hFF;
  localparam int          INT_LEN_DEF = 32;
  localparam logic [15:0] ROM_TOP_DEF = 16'h5FFF;

  typedef enum logic [1:0] {
    ACC_NONE   = 2'd0,
    ACC_MEM_RD = 2'd1,
    ACC_IO_RD  = 2'd2
  } rd_kind_e;

  function automatic rd_kind_e read_kind(input logic mreq_n, input logic iorq_n,
                                         input logic rd_n);
    rd_kind_e k;
    k = ACC_NONE;
    if (!rd_n && !mreq_n)      k = ACC_MEM_RD;
    else if (!rd_n && !iorq_n) k = ACC_IO_RD;
    return k;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bus_responder_int_gen.sv
// +------------------------------------------------------------------+
// | int_gen : vsync edge detect and frame-interrupt down-counter     |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module int_gen
  import lynx_pkg::*;
#(
  parameter int INT_LEN = INT_LEN_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic i_cep,
  input  logic i_vsync,
  output logic o_int_n
);

  localparam logic [7:0] c_len = 8'(INT_LEN);

  logic       r_vsync_d;
  logic [7:0] r_count;
  logic       r_int_n;
  logic       w_vs_edge;

  assign w_vs_edge = i_vsync & ~r_vsync_d;

  // A fresh edge always reloads, so back-to-back frames stretch the pulse.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_vsync_d <= 1'b0;
      r_count   <= 8'd0;
      r_int_n   <= 1'b1;
    end else begin
      r_vsync_d <= i_vsync;
      if (w_vs_edge) begin
        r_count <= c_len;
        r_int_n <= 1'b0;
      end else if (i_cep && (r_count != 8'd0)) begin
        r_count <= r_count - 8'd1;
        if (r_count == 8'd1) r_int_n <= 1'b1;
      end
    end
  end

  assign o_int_n = r_int_n;

endmodule

`default_nettype wire

// File: rtl/bus_responder.sv
// +------------------------------------------------------------------+
// | bus_responder : Z80 target decode, read mux, Lynx port latches   |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module bus_responder
  import lynx_pkg::*;
#(
  parameter int          INT_LEN = INT_LEN_DEF,
  parameter logic [15:0] ROM_TOP = ROM_TOP_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cep,
  input  logic        mreq,
  input  logic        iorq,
  input  logic        rd,
  input  logic        wr,
  input  logic [15:0] a,
  input  logic [7:0]  d,
  output logic [7:0]  q,
  input  logic [7:0]  rom_q,
  input  logic [7:0]  ram_q,
  input  logic [7:0]  key_q,
  input  logic        vsync,
  output logic        int_n,
  output logic        rom_ce,
  output logic        ram_ce,
  output logic        ram_we,
  output logic [7:0]  bank,
  output logic [7:0]  vctl,
  output logic [5:0]  dac
);

  logic       w_rom_ce;
  logic       w_ram_ce;
  logic       w_strobe;
  logic       w_commit;
  rd_kind_e   w_kind;
  logic [7:0] w_rd_data;

  logic       r_strobe_d;
  logic [7:0] r_q;
  logic [7:0] r_bank;
  logic [7:0] r_vctl;
  logic [5:0] r_dac;
  logic       r_ram_we;

  // ROM only answers reads; writes under ROM fall through to RAM.
  assign w_rom_ce = ~mreq & ~r_vctl[5] & (a <= ROM_TOP) & ~rd;
  assign w_ram_ce = ~mreq & ~w_rom_ce;

  assign w_strobe = (~iorq | ~mreq) & ~wr;
  assign w_commit = cep & w_strobe & ~r_strobe_d;

  always_comb begin
    w_rd_data = BYTE_FF;
    w_kind    = read_kind(mreq, iorq, rd);
    case (w_kind)
      ACC_MEM_RD: w_rd_data = w_rom_ce ? rom_q : ram_q;
      ACC_IO_RD: begin
        if (a[7:0] == PORT_VCTL)      w_rd_data = key_q;
        else if (a[7:0] == PORT_BANK) w_rd_data = r_bank;
      end
      default: w_rd_data = BYTE_FF;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_strobe_d <= 1'b0;
      r_q        <= BYTE_FF;
      r_bank     <= 8'h00;
      r_vctl     <= 8'h00;
      r_dac      <= 6'd0;
      r_ram_we   <= 1'b0;
    end else begin
      r_ram_we <= w_commit & ~mreq;
      if (cep) begin
        r_strobe_d <= w_strobe;
        r_q        <= w_rd_data;
      end
      if (w_commit && !iorq) begin
        case (a[7:0])
          PORT_BANK: r_bank <= d;
          PORT_VCTL: r_vctl <= d;
          PORT_DAC:  r_dac  <= d[5:0];
          default:   ;
        endcase
      end
    end
  end

  int_gen #(
    .INT_LEN (INT_LEN)
  ) u_int_gen (
    .clock   (clock),
    .reset   (reset),
    .i_cep   (cep),
    .i_vsync (vsync),
    .o_int_n (int_n)
  );

  assign q      = r_q;
  assign rom_ce = w_rom_ce;
  assign ram_ce = w_ram_ce;
  assign ram_we = r_ram_we;
  assign bank   = r_bank;
  assign vctl   = r_vctl;
  assign dac    = r_dac;

endmodule

`default_nettype wire

// File: tb/tb_bus_responder.sv
// Directed vector table, hand sequences and random traffic against a behavioural model.
`default_nettype none

module tb_bus_responder;

  localparam int INT_LEN = 32;

  logic        clock = 1'b0;
  logic        reset, cep, mreq, iorq, rd, wr, vsync;
  logic [15:0] a;
  logic [7:0]  d, rom_q, ram_q, key_q;
  logic [7:0]  q, bank, vctl;
  logic [5:0]  dac;
  logic        int_n, rom_ce, ram_ce, ram_we;

  bus_responder #(.INT_LEN(INT_LEN), .ROM_TOP(16'h5FFF)) dut (
    .clock(clock), .reset(reset), .cep(cep), .mreq(mreq), .iorq(iorq), .rd(rd), .wr(wr),
    .a(a), .d(d), .q(q), .rom_q(rom_q), .ram_q(ram_q), .key_q(key_q), .vsync(vsync),
    .int_n(int_n), .rom_ce(rom_ce), .ram_ce(ram_ce), .ram_we(ram_we),
    .bank(bank), .vctl(vctl), .dac(dac)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // behavioural model state
  logic [7:0] m_bank, m_vctl, m_q;
  logic [5:0] m_dac;
  logic       m_we;
  int         m_rem;
  bit         m_str_prev, m_vs_prev;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_edge();
    logic       strobe;
    bit         commit;
    logic [7:0] rv;
    if (!reset) begin
      m_bank = 8'h00; m_vctl = 8'h00; m_dac = 6'd0; m_q = 8'hFF; m_we = 1'b0;
      m_rem = 0; m_str_prev = 1'b0; m_vs_prev = 1'b0;
    end else begin
      strobe = (!iorq || !mreq) && !wr;
      commit = cep && strobe && !m_str_prev;
      rv = 8'hFF;
      if (!mreq && !rd)
        rv = (!m_vctl[5] && a <= 16'h5FFF) ? rom_q : ram_q;
      else if (!iorq && !rd) begin
        if (a[7:0] == 8'h80)      rv = key_q;
        else if (a[7:0] == 8'h7F) rv = m_bank;
      end
      if (cep) begin
        m_q = rv;
        m_str_prev = strobe;
      end
      m_we = commit && !mreq;
      if (commit && !iorq) begin
        if (a[7:0] == 8'h7F) m_bank = d;
        if (a[7:0] == 8'h80) m_vctl = d;
        if (a[7:0] == 8'h84) m_dac  = d[5:0];
      end
      if (vsync && !m_vs_prev) m_rem = INT_LEN;
      else if (cep && m_rem > 0) m_rem--;
      m_vs_prev = vsync;
    end
  endtask

  // Inputs are driven just after a rising edge; this checks decode, clocks, then checks state.
  task automatic step();
    logic e_rom;
    #3;
    e_rom = !mreq && !m_vctl[5] && (a <= 16'h5FFF) && !rd;
    chk("rom_ce", rom_ce, e_rom);
    chk("ram_ce", ram_ce, !mreq && !e_rom);
    @(posedge clock);
    model_edge();
    #1;
    chk("q", q, m_q);
    chk("bank", bank, m_bank);
    chk("vctl", vctl, m_vctl);
    chk("dac", dac, m_dac);
    chk("ram_we", ram_we, m_we);
    chk("int_n", int_n, (m_rem == 0));
  endtask

  task automatic bus(input logic c, input logic m, input logic i, input logic r,
                     input logic w, input logic [15:0] aa, input logic [7:0] dd);
    cep = c; mreq = m; iorq = i; rd = r; wr = w; a = aa; d = dd;
  endtask

  typedef struct packed {
    logic        cep, mreq, iorq, rd, wr;
    logic [15:0] a;
    logic [7:0]  d, key, eq, eb, ev;
    logic [5:0]  ed;
    logic        ew, erom, eram;
  } vec_t;

  function automatic vec_t mk(input logic c, input logic m, input logic i, input logic r,
                              input logic w, input logic [15:0] aa, input logic [7:0] dd,
                              input logic [7:0] eq, input logic [7:0] eb, input logic [7:0] ev,
                              input logic [5:0] ed, input logic ew, input logic erom,
                              input logic eram);
    vec_t v;
    v.cep = c; v.mreq = m; v.iorq = i; v.rd = r; v.wr = w; v.a = aa; v.d = dd;
    v.key = 8'hFE; v.eq = eq; v.eb = eb; v.ev = ev; v.ed = ed;
    v.ew = ew; v.erom = erom; v.eram = eram;
    return v;
  endfunction

  vec_t tbl [25];
  int   low_cnt;
  int   hold;
  int   op;
  logic [7:0] ports [4];

  initial begin
    //            c  m  i  r  w  a         d       q      bank   vctl   dac   we rom ram
    tbl[0]  = mk(1, 1, 0, 1, 0, 16'h007F, 8'hA5, 8'hFF, 8'hA5, 8'h00, 6'h00, 0, 0, 0);
    tbl[1]  = mk(1, 1, 0, 1, 0, 16'h007F, 8'h11, 8'hFF, 8'hA5, 8'h00, 6'h00, 0, 0, 0);
    tbl[2]  = mk(1, 1, 0, 1, 0, 16'h007F, 8'h11, 8'hFF, 8'hA5, 8'h00, 6'h00, 0, 0, 0);
    tbl[3]  = mk(1, 1, 1, 1, 1, 16'h0000, 8'h00, 8'hFF, 8'hA5, 8'h00, 6'h00, 0, 0, 0);
    tbl[4]  = mk(1, 1, 0, 1, 0, 16'h0084, 8'hFF, 8'hFF, 8'hA5, 8'h00, 6'h3F, 0, 0, 0);
    tbl[5]  = mk(1, 1, 1, 1, 1, 16'h0000, 8'h00, 8'hFF, 8'hA5, 8'h00, 6'h3F, 0, 0, 0);
    tbl[6]  = mk(1, 0, 1, 0, 1, 16'h0100, 8'h00, 8'h3C, 8'hA5, 8'h00, 6'h3F, 0, 1, 0);
    tbl[7]  = mk(1, 1, 0, 1, 0, 16'h0080, 8'h20, 8'hFF, 8'hA5, 8'h20, 6'h3F, 0, 0, 0);
    tbl[8]  = mk(1, 1, 1, 1, 1, 16'h0000, 8'h00, 8'hFF, 8'hA5, 8'h20, 6'h3F, 0, 0, 0);
    tbl[9]  = mk(1, 0, 1, 0, 1, 16'h0100, 8'h00, 8'h5A, 8'hA5, 8'h20, 6'h3F, 0, 0, 1);
    tbl[10] = mk(1, 1, 0, 1, 0, 16'h0080, 8'h00, 8'hFF, 8'hA5, 8'h00, 6'h3F, 0, 0, 0);
    tbl[11] = mk(1, 1, 1, 1, 1, 16'h0000, 8'h00, 8'hFF, 8'hA5, 8'h00, 6'h3F, 0, 0, 0);
    tbl[12] = mk(1, 0, 1, 1, 0, 16'h0100, 8'h77, 8'hFF, 8'hA5, 8'h00, 6'h3F, 1, 0, 1);
    tbl[13] = mk(1, 0, 1, 1, 0, 16'h0100, 8'h77, 8'hFF, 8'hA5, 8'h00, 6'h3F, 0, 0, 1);
    tbl[14] = mk(1, 1, 1, 1, 1, 16'h0000, 8'h00, 8'hFF, 8'hA5, 8'h00, 6'h3F, 0, 0, 0);
    tbl[15] = mk(1, 1, 0, 0, 1, 16'h0080, 8'h00, 8'hFE, 8'hA5, 8'h00, 6'h3F, 0, 0, 0);
    tbl[16] = mk(1, 1, 0, 0, 1, 16'h0055, 8'h00, 8'hFF, 8'hA5, 8'h00, 6'h3F, 0, 0, 0);
    tbl[17] = mk(1, 1, 0, 0, 1, 16'h007F, 8'h00, 8'hA5, 8'hA5, 8'h00, 6'h3F, 0, 0, 0);
    tbl[18] = mk(0, 1, 0, 0, 1, 16'h0080, 8'h00, 8'hA5, 8'hA5, 8'h00, 6'h3F, 0, 0, 0);
    tbl[19] = mk(1, 1, 1, 1, 1, 16'h0000, 8'h00, 8'hFF, 8'hA5, 8'h00, 6'h3F, 0, 0, 0);
    tbl[20] = mk(0, 1, 0, 1, 0, 16'h007F, 8'h3C, 8'hFF, 8'hA5, 8'h00, 6'h3F, 0, 0, 0);
    tbl[21] = mk(1, 1, 0, 1, 0, 16'h007F, 8'h3C, 8'hFF, 8'h3C, 8'h00, 6'h3F, 0, 0, 0);
    tbl[22] = mk(1, 1, 1, 1, 1, 16'h0000, 8'h00, 8'hFF, 8'h3C, 8'h00, 6'h3F, 0, 0, 0);
    tbl[23] = mk(1, 0, 1, 0, 1, 16'h5FFF, 8'h00, 8'h3C, 8'h3C, 8'h00, 6'h3F, 0, 1, 0);
    tbl[24] = mk(1, 0, 1, 0, 1, 16'h6000, 8'h00, 8'h5A, 8'h3C, 8'h00, 6'h3F, 0, 0, 1);

    ports[0] = 8'h7F; ports[1] = 8'h80; ports[2] = 8'h84; ports[3] = 8'h55;

    // reset held 4 clocks
    reset = 1'b0; vsync = 1'b0;
    rom_q = 8'h3C; ram_q = 8'h5A; key_q = 8'hFE;
    bus(1, 1, 1, 1, 1, 16'h0000, 8'h00);
    m_bank = 8'h00; m_vctl = 8'h00; m_dac = 6'd0; m_q = 8'hFF; m_we = 1'b0;
    m_rem = 0; m_str_prev = 1'b0; m_vs_prev = 1'b0;
    repeat (4) step();
    chk("rst_int", int_n, 1'b1);
    chk("rst_q", q, 8'hFF);
    chk("rst_bank", bank, 8'h00);
    chk("rst_vctl", vctl, 8'h00);
    chk("rst_dac", dac, 6'd0);
    chk("rst_we", ram_we, 1'b0);
    reset = 1'b1;

    // directed vector table
    for (int i = 0; i < 25; i++) begin
      bus(tbl[i].cep, tbl[i].mreq, tbl[i].iorq, tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d);
      key_q = tbl[i].key;
      step();
      chk($sformatf("vec%0d_q", i), q, tbl[i].eq);
      chk($sformatf("vec%0d_bank", i), bank, tbl[i].eb);
      chk($sformatf("vec%0d_vctl", i), vctl, tbl[i].ev);
      chk($sformatf("vec%0d_dac", i), dac, tbl[i].ed);
      chk($sformatf("vec%0d_we", i), ram_we, tbl[i].ew);
      chk($sformatf("vec%0d_rom", i), rom_ce, tbl[i].erom);
      chk($sformatf("vec%0d_ram", i), ram_ce, tbl[i].eram);
    end

    // single vsync edge, cep every clock: int low for INT_LEN clocks after the load
    bus(1, 1, 1, 1, 1, 16'h0000, 8'h00);
    vsync = 1'b1;
    step();
    low_cnt = (int_n == 1'b0) ? 1 : 0;
    for (int k = 1; k <= 200 && int_n == 1'b0; k++) begin
      if (k == 4) vsync = 1'b0;
      step();
      if (int_n == 1'b0) low_cnt++;
    end
    chk("int_single_len", low_cnt, 16'd32);

    // second edge 10 clocks after the first restarts the full count
    vsync = 1'b1;
    step();
    low_cnt = (int_n == 1'b0) ? 1 : 0;
    for (int k = 1; k <= 200 && int_n == 1'b0; k++) begin
      if (k == 4)  vsync = 1'b0;
      if (k == 10) vsync = 1'b1;
      step();
      if (int_n == 1'b0) low_cnt++;
    end
    chk("int_retrigger_len", low_cnt, 16'd42);

    // half-rate cep: only cep clocks count down
    vsync = 1'b0; step();
    vsync = 1'b1; cep = 1'b1;
    step();
    low_cnt = (int_n == 1'b0) ? 1 : 0;
    for (int k = 1; k <= 300 && int_n == 1'b0; k++) begin
      cep = (k % 2 == 0);
      step();
      if (int_n == 1'b0) low_cnt++;
    end
    chk("int_halfrate_len", low_cnt, 16'd64);
    vsync = 1'b0;
    bus(1, 1, 1, 1, 1, 16'h0000, 8'h00);
    step();

    // write commit and vsync edge in the same clock
    bus(1, 1, 0, 1, 0, 16'h007F, 8'hC3);
    vsync = 1'b1;
    step();
    chk("simul_bank", bank, 8'hC3);
    chk("simul_int", int_n, 1'b0);
    bus(1, 1, 1, 1, 1, 16'h0000, 8'h00);
    vsync = 1'b0;
    repeat (40) step();

    // reset while a write is held low: commits only on the first cep after release
    bus(1, 1, 0, 1, 0, 16'h0084, 8'h15);
    reset = 1'b0;
    repeat (2) step();
    chk("rstwr_dac_in_reset", dac, 6'd0);
    reset = 1'b1; cep = 1'b0;
    step();
    chk("rstwr_dac_nocep", dac, 6'd0);
    cep = 1'b1;
    step();
    chk("rstwr_dac_commit", dac, 6'h15);
    d = 8'h2A;
    step();
    chk("rstwr_dac_single", dac, 6'h15);
    bus(1, 1, 1, 1, 1, 16'h0000, 8'h00);
    step();

    // random bus traffic against the model
    hold = 0; op = 0;
    for (int n = 0; n < 1500; n++) begin
      if (hold == 0) begin
        hold = $urandom_range(1, 4);
        op   = $urandom_range(0, 4);
        a    = 16'($urandom);
        d    = 8'($urandom);
        if (op >= 3) a[7:0] = ports[$urandom_range(0, 3)];
        case (op)
          1: begin mreq = 0; iorq = 1; rd = 0; wr = 1; end
          2: begin mreq = 0; iorq = 1; rd = 1; wr = 0; end
          3: begin mreq = 1; iorq = 0; rd = 0; wr = 1; end
          4: begin mreq = 1; iorq = 0; rd = 1; wr = 0; end
          default: begin mreq = 1; iorq = 1; rd = 1; wr = 1; end
        endcase
      end
      hold--;
      cep   = 1'($urandom_range(0, 1));
      rom_q = 8'($urandom);
      ram_q = 8'($urandom);
      key_q = 8'($urandom);
      if ($urandom_range(0, 39) == 0) vsync = ~vsync;
      reset = ($urandom_range(0, 399) != 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
